// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA send scheduler.
package dma_pkg;

  localparam int unsigned TileBytes    = 36;
  localparam int unsigned DefaultAddrW = 16;
  localparam int unsigned DefaultTileW = TileBytes * 8;

  typedef enum logic [1:0] {
    CmdNone    = 2'd0,
    CmdRead    = 2'd1,
    CmdWrite   = 2'd2,
    CmdEndProg = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StOffer,
    StWaitDone
  } sched_state_e;

  // Bit positions of the one-hot grant vector.
  localparam int unsigned GntRd = 0;
  localparam int unsigned GntWr = 1;
  localparam int unsigned GntEp = 2;

endpackage

// File: rtl/dma_send_scheduler_if.sv
// Queue-pop and sender-command signals of the DMA send scheduler.
interface dma_send_scheduler_if
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned TILE_W = DefaultTileW
);

  logic [ADDR_W-1:0] rd_q_data;
  logic              rd_q_available;
  logic              rd_q_re;
  logic [ADDR_W-1:0] wr_q_addr;
  logic [TILE_W-1:0] wr_q_tile;
  logic              wr_q_available;
  logic              wr_q_re;
  logic              ep_q_available;
  logic              ep_q_re;
  logic              cmd_valid;
  logic              cmd_ready;
  cmd_type_e         cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [TILE_W-1:0] cmd_tile;
  logic              cmd_done;
  logic              busy;
  logic              proto_err;

  modport master (
    input  rd_q_data, rd_q_available, wr_q_addr, wr_q_tile, wr_q_available, ep_q_available,
    input  cmd_ready, cmd_done,
    output rd_q_re, wr_q_re, ep_q_re,
    output cmd_valid, cmd_type, cmd_addr, cmd_tile, busy, proto_err
  );

  modport slave (
    output rd_q_data, rd_q_available, wr_q_addr, wr_q_tile, wr_q_available, ep_q_available,
    output cmd_ready, cmd_done,
    input  rd_q_re, wr_q_re, ep_q_re,
    input  cmd_valid, cmd_type, cmd_addr, cmd_tile, busy, proto_err
  );

endinterface

// File: rtl/dma_sched_pick.sv
// Combinational queue arbiter: read priority bounded by the read streak while writes wait.
module dma_sched_pick
  import dma_pkg::*;
#(
  parameter int unsigned READ_BURST_MAX = 4
) (
  input  logic       rd_avail_i,
  input  logic       wr_avail_i,
  input  logic       ep_avail_i,
  input  logic [3:0] read_streak_i,
  output logic [2:0] grant_o
);

  localparam logic [3:0] BurstMax = 4'(READ_BURST_MAX);

  // End-program sits below writes, so it can never win while a write is queued.
  always_comb begin
    grant_o = '0;
    if (wr_avail_i && (read_streak_i >= BurstMax)) begin
      grant_o[GntWr] = 1'b1;
    end else if (rd_avail_i) begin
      grant_o[GntRd] = 1'b1;
    end else if (wr_avail_i) begin
      grant_o[GntWr] = 1'b1;
    end else if (ep_avail_i) begin
      grant_o[GntEp] = 1'b1;
    end
  end

endmodule

// File: rtl/dma_send_scheduler.sv
// Pops read/write/end-program queues and offers one command at a time to the packet sender.
// Optional grant counters: define DMA_SCHED_STATS_EN.
module dma_send_scheduler
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefaultAddrW,
  parameter int unsigned TILE_W         = DefaultTileW,
  parameter int unsigned READ_BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dma_send_scheduler_if.master bus
`ifdef DMA_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_rd_grants,
  output logic [15:0]          stat_wr_grants,
  output logic [15:0]          stat_ep_grants
`endif
);

  sched_state_e      state_q, state_d;
  cmd_type_e         type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [3:0]        streak_q, streak_d;
  logic              perr_q, perr_d;
  logic [2:0]        grant;
  logic [2:0]        pop;

  dma_sched_pick #(
    .READ_BURST_MAX(READ_BURST_MAX)
  ) u_pick (
    .rd_avail_i   (bus.rd_q_available),
    .wr_avail_i   (bus.wr_q_available),
    .ep_avail_i   (bus.ep_q_available),
    .read_streak_i(streak_q),
    .grant_o      (grant)
  );

  // Pops are combinational from the IDLE state so queue data lands during FETCH.
  assign pop = ((state_q == StIdle) && !reset) ? grant : 3'b000;

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    addr_d   = addr_q;
    tile_d   = tile_q;
    streak_d = streak_q;
    perr_d   = perr_q | (bus.cmd_done && (state_q != StWaitDone));
    unique case (state_q)
      StIdle: begin
        if (!bus.wr_q_available) streak_d = '0;
        if (pop[GntRd]) begin
          type_d  = CmdRead;
          state_d = StFetch;
          if (bus.wr_q_available && (streak_q != 4'hF)) streak_d = streak_q + 4'd1;
        end else if (pop[GntWr]) begin
          type_d   = CmdWrite;
          state_d  = StFetch;
          streak_d = '0;
        end else if (pop[GntEp]) begin
          type_d  = CmdEndProg;
          state_d = StFetch;
        end
      end
      StFetch: begin
        case (type_q)
          CmdRead: begin
            addr_d = bus.rd_q_data;
            tile_d = '0;
          end
          CmdWrite: begin
            addr_d = bus.wr_q_addr;
            tile_d = bus.wr_q_tile;
          end
          default: ;
        endcase
        state_d = StOffer;
      end
      StOffer: begin
        if (bus.cmd_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (bus.cmd_done) begin
          state_d = StIdle;
          type_d  = CmdNone;
          addr_d  = '0;
          tile_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      type_q   <= CmdNone;
      addr_q   <= '0;
      tile_q   <= '0;
      streak_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      tile_q   <= tile_d;
      streak_q <= streak_d;
      perr_q   <= perr_d;
    end
  end

  assign bus.rd_q_re   = pop[GntRd];
  assign bus.wr_q_re   = pop[GntWr];
  assign bus.ep_q_re   = pop[GntEp];
  assign bus.cmd_valid = (state_q == StOffer);
  assign bus.cmd_type  = type_q;
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_tile  = tile_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.proto_err = perr_q;

`ifdef DMA_SCHED_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] ep_cnt_q, ep_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + {15'd0, pop[GntRd]};
    wr_cnt_d = wr_cnt_q + {15'd0, pop[GntWr]};
    ep_cnt_d = ep_cnt_q + {15'd0, pop[GntEp]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      ep_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      ep_cnt_q <= ep_cnt_d;
    end
  end

  assign stat_rd_grants = rd_cnt_q;
  assign stat_wr_grants = wr_cnt_q;
  assign stat_ep_grants = ep_cnt_q;
`endif

endmodule

// File: tb/tb_dma_send_scheduler.sv
// Directed bench for dma_send_scheduler: small queue/sender model plus per-scenario checks.
module tb_dma_send_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_send_scheduler_if bus ();

`ifdef DMA_SCHED_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_ep;
`endif

  dma_send_scheduler #(
    .READ_BURST_MAX(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef DMA_SCHED_STATS_EN
    ,
    .stat_rd_grants(stat_rd),
    .stat_wr_grants(stat_wr),
    .stat_ep_grants(stat_ep)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Queue / sender model state
  int           rd_left, wr_left, ep_left, rd_idx, wr_idx;
  logic [15:0]  rd_addr_arr[4];
  logic [15:0]  wr_addr_arr[4];
  logic [287:0] wr_tile_arr[4];
  logic [15:0]  p_rd_data, p_wr_addr;
  logic [287:0] p_wr_tile;
  logic         p_done, p_reset, auto_ready;
  int           done_delay, wait_cnt, dual_pop, ep_with_wr;
  byte          grant_log[$];
  logic [1:0]   log_type[$];
  logic [15:0]  log_addr[$];
  logic [287:0] log_tile[$];

  // One clock: apply inputs computed last cycle, then observe and advance the model.
  task automatic cycle();
    @(posedge clk);
    #1;
    reset              = p_reset;
    bus.rd_q_available = (rd_left > 0);
    bus.wr_q_available = (wr_left > 0);
    bus.ep_q_available = (ep_left > 0);
    bus.rd_q_data      = p_rd_data;
    bus.wr_q_addr      = p_wr_addr;
    bus.wr_q_tile      = p_wr_tile;
    bus.cmd_ready      = auto_ready;
    bus.cmd_done       = p_done;
    #1;
    p_done = 1'b0;
    if (({1'b0, bus.rd_q_re} + {1'b0, bus.wr_q_re} + {1'b0, bus.ep_q_re}) > 2'd1) dual_pop++;
    if (bus.rd_q_re) begin
      grant_log.push_back("R");
      p_rd_data = rd_addr_arr[rd_idx % 4];
      rd_idx++;
      rd_left--;
    end
    if (bus.wr_q_re) begin
      grant_log.push_back("W");
      p_wr_addr = wr_addr_arr[wr_idx % 4];
      p_wr_tile = wr_tile_arr[wr_idx % 4];
      wr_idx++;
      wr_left--;
    end
    if (bus.ep_q_re) begin
      grant_log.push_back("E");
      if (bus.wr_q_available) ep_with_wr++;
      ep_left--;
    end
    if (bus.cmd_valid && bus.cmd_ready) begin
      log_type.push_back(bus.cmd_type);
      log_addr.push_back(bus.cmd_addr);
      log_tile.push_back(bus.cmd_tile);
      wait_cnt = done_delay;
    end else if (wait_cnt > 0) begin
      wait_cnt--;
      if (wait_cnt == 0) p_done = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p_reset = 1'b1;
    rd_left = 0; wr_left = 0; ep_left = 0; rd_idx = 0; wr_idx = 0;
    p_rd_data = '0; p_wr_addr = '0; p_wr_tile = '0; p_done = 1'b0;
    auto_ready = 1'b0; done_delay = 0; wait_cnt = 0; dual_pop = 0; ep_with_wr = 0;
    grant_log.delete(); log_type.delete(); log_addr.delete(); log_tile.delete();
    cycle();
    cycle();
  endtask

  task automatic release_reset();
    p_reset = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    rd_left = 1000; wr_left = 1000; ep_left = 1000;
    rd_addr_arr[0] = 16'h1234;
    cycle();
    checks++; if (bus.rd_q_re !== 1'b0) begin failures++;
      $display("FAIL reset_rd_re got=%b exp=0", bus.rd_q_re); end
    checks++; if (bus.cmd_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b exp=0", bus.cmd_valid); end
    checks++; if (bus.cmd_type !== 2'd0) begin failures++;
      $display("FAIL reset_type got=%0d exp=0", bus.cmd_type); end
    checks++; if (bus.cmd_addr !== 16'h0 || bus.cmd_tile !== 288'h0) begin failures++;
      $display("FAIL reset_fields got=%h/%h exp=0", bus.cmd_addr, bus.cmd_tile); end
    checks++; if (bus.busy !== 1'b0 || bus.proto_err !== 1'b0) begin failures++;
      $display("FAIL reset_busy_err got=%b%b exp=00", bus.busy, bus.proto_err); end
`ifdef DMA_SCHED_STATS_EN
    checks++; if (stat_rd !== 16'd0 || stat_wr !== 16'd0 || stat_ep !== 16'd0) begin failures++;
      $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", stat_rd, stat_wr, stat_ep); end
`endif
    release_reset();
    checks++; if ({bus.rd_q_re, bus.wr_q_re, bus.ep_q_re} !== 3'b100) begin failures++;
      $display("FAIL first_pop got=%b exp=100", {bus.rd_q_re, bus.wr_q_re, bus.ep_q_re}); end
    cycle();
    checks++; if (bus.rd_q_re !== 1'b0 || bus.cmd_valid !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL fetch_cycle got re=%b valid=%b busy=%b exp re=0 valid=0 busy=1",
               bus.rd_q_re, bus.cmd_valid, bus.busy);
    end
    cycle();
    checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_type !== 2'd1) begin failures++;
      $display("FAIL offer_read got valid=%b type=%0d exp valid=1 type=1",
               bus.cmd_valid, bus.cmd_type); end
    checks++; if (bus.cmd_addr !== 16'h1234 || bus.cmd_tile !== 288'h0) begin failures++;
      $display("FAIL offer_read_fields got=%h/%h exp=1234/0", bus.cmd_addr, bus.cmd_tile); end
  endtask

  task automatic test_burst_order();
    string exp_order = "RRRRWRRRRW";
    do_reset();
    rd_left = 1000; wr_left = 1000;
    auto_ready = 1'b1; done_delay = 3;
    release_reset();
    for (int i = 0; i < 300 && grant_log.size() < 10; i++) cycle();
    checks++; if (grant_log.size() < 10) begin failures++;
      $display("FAIL burst_timeout got=%0d grants exp=10", grant_log.size()); end
    for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
      checks++; if (grant_log[i] !== exp_order[i]) begin failures++;
        $display("FAIL burst_grant_%0d got=%c exp=%c", i, grant_log[i], exp_order[i]); end
    end
    checks++; if (dual_pop !== 0) begin failures++;
      $display("FAIL burst_dual_pop got=%0d exp=0", dual_pop); end
  endtask

  task automatic test_write_then_ep();
    logic [287:0] t0, t1;
    t0 = {36{8'hA5}};
    t1 = {18{16'hA55A}};
    do_reset();
    wr_left = 2; ep_left = 1;
    wr_addr_arr[0] = 16'h0100; wr_tile_arr[0] = t0;
    wr_addr_arr[1] = 16'h0200; wr_tile_arr[1] = t1;
    auto_ready = 1'b1; done_delay = 2;
    release_reset();
    for (int i = 0; i < 100 && !(log_type.size() == 3 && !bus.busy); i++) cycle();
    checks++; if (log_type.size() != 3) begin failures++;
      $display("FAIL wep_count got=%0d exp=3", log_type.size()); end
    if (log_type.size() == 3) begin
      checks++; if (log_type[0] !== 2'd2 || log_addr[0] !== 16'h0100 || log_tile[0] !== t0) begin
        failures++;
        $display("FAIL wep_write0 got=%0d/%h/%h exp=2/0100/%h", log_type[0], log_addr[0],
                 log_tile[0], t0);
      end
      checks++; if (log_type[1] !== 2'd2 || log_addr[1] !== 16'h0200 || log_tile[1] !== t1) begin
        failures++;
        $display("FAIL wep_write1 got=%0d/%h/%h exp=2/0200/%h", log_type[1], log_addr[1],
                 log_tile[1], t1);
      end
      checks++; if (log_type[2] !== 2'd3 || log_addr[2] !== 16'h0 || log_tile[2] !== 288'h0) begin
        failures++;
        $display("FAIL wep_endprog got=%0d/%h/%h exp=3/0/0", log_type[2], log_addr[2],
                 log_tile[2]);
      end
    end
    checks++; if (ep_with_wr !== 0) begin failures++;
      $display("FAIL wep_ep_with_write got=%0d exp=0", ep_with_wr); end
  endtask

  task automatic test_ready_stall();
    do_reset();
    rd_left = 5;
    rd_addr_arr[0] = 16'hBEEF;
    release_reset();
    for (int i = 0; i < 10 && !bus.cmd_valid; i++) cycle();
    checks++; if (bus.cmd_valid !== 1'b1) begin failures++;
      $display("FAIL stall_offer got=%b exp=1", bus.cmd_valid); end
    for (int i = 0; i < 9; i++) begin
      cycle();
      checks++;
      if (bus.cmd_valid !== 1'b1 || bus.cmd_type !== 2'd1 || bus.cmd_addr !== 16'hBEEF ||
          bus.cmd_tile !== 288'h0) begin
        failures++;
        $display("FAIL stall_hold_%0d got valid=%b type=%0d addr=%h exp 1/1/beef",
                 i, bus.cmd_valid, bus.cmd_type, bus.cmd_addr);
      end
    end
    checks++; if (grant_log.size() != 1) begin failures++;
      $display("FAIL stall_extra_pops got=%0d exp=1", grant_log.size()); end
    auto_ready = 1'b1;
    cycle();
    checks++; if (log_type.size() != 1) begin failures++;
      $display("FAIL stall_accept got=%0d exp=1", log_type.size()); end
    cycle();
    checks++; if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b1 || bus.cmd_type !== 2'd1) begin
      failures++;
      $display("FAIL stall_wait got valid=%b busy=%b type=%0d exp 0/1/1",
               bus.cmd_valid, bus.busy, bus.cmd_type);
    end
    rd_left = 0;
    p_done = 1'b1;
    cycle();
    cycle();
    checks++; if (bus.busy !== 1'b0 || bus.cmd_type !== 2'd0 || bus.cmd_addr !== 16'h0) begin
      failures++;
      $display("FAIL stall_done got busy=%b type=%0d addr=%h exp 0/0/0",
               bus.busy, bus.cmd_type, bus.cmd_addr);
    end
    checks++; if (bus.proto_err !== 1'b0) begin failures++;
      $display("FAIL stall_proto_err got=%b exp=0", bus.proto_err); end
  endtask

  task automatic test_proto_err();
    do_reset();
    release_reset();
    checks++; if (bus.proto_err !== 1'b0) begin failures++;
      $display("FAIL perr_initial got=%b exp=0", bus.proto_err); end
    p_done = 1'b1;
    cycle();
    cycle();
    checks++; if (bus.proto_err !== 1'b1 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL perr_set got err=%b busy=%b exp 1/0", bus.proto_err, bus.busy); end
    repeat (3) cycle();
    checks++; if (bus.proto_err !== 1'b1 || grant_log.size() != 0) begin failures++;
      $display("FAIL perr_sticky got err=%b pops=%0d exp 1/0", bus.proto_err, grant_log.size());
    end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    rd_left = 1;
    rd_addr_arr[0] = 16'h0042;
    release_reset();
    for (int i = 0; i < 10 && !bus.cmd_valid; i++) cycle();
    checks++; if (bus.cmd_valid !== 1'b1) begin failures++;
      $display("FAIL midreset_offer got=%b exp=1", bus.cmd_valid); end
    reset = 1'b1;
    p_reset = 1'b1;
    #1;
    checks++; if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_type !== 2'd0) begin
      failures++;
      $display("FAIL midreset_async got valid=%b busy=%b type=%0d exp 0/0/0",
               bus.cmd_valid, bus.busy, bus.cmd_type);
    end
  endtask

  task automatic test_read_stats();
    do_reset();
    rd_left = 3;
    auto_ready = 1'b1; done_delay = 1;
    release_reset();
    for (int i = 0; i < 100 && !(log_type.size() == 3 && !bus.busy); i++) cycle();
    checks++; if (log_type.size() != 3) begin failures++;
      $display("FAIL stats_reads got=%0d exp=3", log_type.size()); end
`ifdef DMA_SCHED_STATS_EN
    checks++; if (stat_rd !== 16'd3 || stat_wr !== 16'd0 || stat_ep !== 16'd0) begin failures++;
      $display("FAIL stats_counts got=%0d/%0d/%0d exp=3/0/0", stat_rd, stat_wr, stat_ep); end
`endif
  endtask

  initial begin
    test_reset();
    test_burst_order();
    test_write_then_ep();
    test_ready_stall();
    test_proto_err();
    test_reset_mid_offer();
    test_read_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dma_send_scheduler.md
Name: dma_send_scheduler

Overview:
- Sequences outbound DMA traffic for the packet-sending stage.
- Pops the read-request, write and end-program queues; arbitrates among them with bounded read priority; hands exactly one command at a time to the packet sender over a valid/ready/done handshake.
- Guarantees an end-program notification is never issued while a write is still queued.

Parameters:
- ADDR_W, 16, host address width.
- TILE_W, 288, write payload width (18x16).
- READ_BURST_MAX, 4, consecutive read grants allowed while a write is pending (range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rd_q_data  in  ADDR_W  read-request address; valid the cycle after rd_q_re.
- rd_q_available  in  1  read queue non-empty.
- rd_q_re  out  1  read-queue pop, single-cycle pulse.
- wr_q_addr  in  ADDR_W  write host address; valid the cycle after wr_q_re.
- wr_q_tile  in  TILE_W  write payload; valid the cycle after wr_q_re.
- wr_q_available  in  1  write queue non-empty.
- wr_q_re  out  1  write-queue pop pulse.
- ep_q_available  in  1  end-program queue non-empty.
- ep_q_re  out  1  end-program pop pulse.
- cmd_valid  out  1  command offered to the sender.
- cmd_ready  in  1  sender accepts the command.
- cmd_type  out  2  0=NONE, 1=READ, 2=WRITE, 3=END_PROG.
- cmd_addr  out  ADDR_W  address; zero for END_PROG.
- cmd_tile  out  TILE_W  payload; zero unless WRITE.
- cmd_done  in  1  pulse: sender finished transmitting the last byte.
- busy  out  1  high in every state except IDLE.
- proto_err  out  1  sticky; set on cmd_done outside WAIT_DONE.

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0 (cmd_type=NONE, cmd_addr=0, cmd_tile=0); read_streak=0; proto_err=0.
- State IDLE, priority evaluated every cycle:
  - If wr_q_available and read_streak>=READ_BURST_MAX: pop write.
  - Else if rd_q_available: pop read.
  - Else if wr_q_available: pop write.
  - Else if ep_q_available: pop end-program.
  - End-program is granted only when wr_q_available=0 in that same cycle.
- Pop action: assert the matching *_re for exactly one cycle, latch the type, go to FETCH.
- FETCH (1 cycle): capture the queue data into cmd_addr/cmd_tile (END_PROG captures nothing), then go to OFFER.
- OFFER: cmd_valid=1 with fields stable. On cmd_valid&&cmd_ready, drop cmd_valid next cycle and go to WAIT_DONE.
- WAIT_DONE: on cmd_done, go to IDLE and clear cmd_type/cmd_addr/cmd_tile. A new pop may occur no earlier than the cycle after return to IDLE.
- Latency: pop to cmd_valid is 2 cycles. Minimum command period is 4 cycles plus sender time.
- read_streak (4-bit, saturating at 15):
  - +1 on a read grant while wr_q_available=1.
  - Cleared on a write grant.
  - Cleared in any IDLE cycle with wr_q_available=0.
- cmd_done in IDLE/FETCH/OFFER: ignored for sequencing; sets proto_err.
- cmd_ready when cmd_valid=0: ignored.
- Queue available flags dropping after pop: no effect. Data is captured once in FETCH.
- Simultaneous availability of all queues: the priority above decides. Two pops never occur in the same cycle.
- Reset mid-command: state is lost and the command is abandoned. The sender is reset together with this block.

Optional Feature:
- Macro DMA_SCHED_STATS_EN.
  - Defined: adds three 16-bit outputs stat_rd_grants, stat_wr_grants, stat_ep_grants. Each increments on its pop pulse, wraps at 0xFFFF->0, and is reset to 0.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dma_pkg holds:
  - the cmd_type_e enum (NONE/READ/WRITE/END_PROG);
  - the sched state enum (IDLE/FETCH/OFFER/WAIT_DONE);
  - ADDR_W/TILE_W defaults;
  - the TILE_BYTES=36 constant.
- One sub-module, dma_sched_pick: combinational priority and starvation select. Inputs are the three available flags and read_streak; output is a one-hot grant.

Test Plan:
- Reset with all queues available, deassert reset -> next cycle rd_q_re=1 only; cmd_valid at +2 with cmd_type=1 and cmd_addr equal to rd_q_data (e.g. 0x1234).
- Read and write queues permanently available, READ_BURST_MAX=4, cmd_ready=1, cmd_done 3 cycles after accept -> grant order R,R,R,R,W,R,R,R,R,W.
- Write queue holds 2 entries and end-program is pending -> two WRITE commands (tile 0xA5... pattern) delivered intact, then END_PROG with cmd_addr=0 and cmd_tile=0.
- cmd_ready held low 10 cycles in OFFER -> cmd_valid and all fields stable; no further *_re pulses; accept on cycle 11.
- cmd_done pulsed while IDLE -> proto_err=1 and stays 1; state remains IDLE; no pop.
- Reset asserted mid-OFFER -> cmd_valid=0 and busy=0 the same cycle, asynchronously; with DMA_SCHED_STATS_EN defined, after 3 reads the counters show stat_rd_grants=3 and the other two 0.
